// File: rtl/axi4_lite_master_adaptor_if.sv
// rtl/axi4_lite_master_adaptor_if.sv - AXI4-Lite channel bundle between master and slave adaptors
interface axi4_lite_master_adaptor_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axi4_lite_master_adaptor.sv
// rtl/axi4_lite_master_adaptor.sv - single-outstanding AXI4-Lite master driven by a valid/ready command port
// Optional watchdog: define AXI4_LITE_MASTER_TIMEOUT_EN to abort stalled transactions after TIMEOUT_CYCLES.
module axi4_lite_master_adaptor #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    cmd_valid_in,
    output logic                    cmd_ready_out,
    input  logic                    cmd_write_in,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr_in,
    input  logic [2:0]              cmd_prot_in,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata_in,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb_in,
    output logic                    rsp_valid_out,
    input  logic                    rsp_ready_in,
    output logic                    rsp_write_out,
    output logic [1:0]              rsp_resp_out,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_out,
    axi4_lite_master_adaptor_if.master axi
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES out of range 2..65535");
    end

    typedef enum logic [2:0] {IDLE, WRITE, WRESP, RADDR, RDATA, RSP} state_t;

    // Every bus-facing output lives in this one register bank so reset clears all of it together.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] awaddr;
        logic [2:0]            awprot;
        logic                  awvalid;
        logic [DATA_WIDTH-1:0] wdata;
        logic [STRB_WIDTH-1:0] wstrb;
        logic                  wvalid;
        logic                  bready;
        logic [ADDR_WIDTH-1:0] araddr;
        logic [2:0]            arprot;
        logic                  arvalid;
        logic                  rready;
        logic                  rsp_valid;
        logic                  rsp_write;
        logic [1:0]            rsp_resp;
        logic [DATA_WIDTH-1:0] rsp_rdata;
    } regs_t;

    state_t state, state_d;
    regs_t  r, n;

    assign cmd_ready_out = (state == IDLE) && !areset;

`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wd_cnt;
    logic        busy;
    logic        wd_expire;

    assign busy      = (state == WRITE) || (state == WRESP) || (state == RADDR) || (state == RDATA);
    assign wd_expire = busy && (wd_cnt == WD_LAST);

    // Held at zero outside the bus phases, so it restarts on every entry to WRITE/RADDR.
    always_ff @(posedge aclk) begin
        if (areset || !busy) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 16'd1;
        end
    end
`endif

    always_ff @(posedge aclk) begin
        if (areset) begin
            state <= IDLE;
            r     <= '0;
        end else begin
            state <= state_d;
            r     <= n;
        end
    end

    always_comb begin
        n       = r;
        state_d = state;
        case (state)
            IDLE: begin
                if (cmd_valid_in && cmd_ready_out) begin
                    n.rsp_write = cmd_write_in;
                    if (cmd_write_in) begin
                        n.awaddr    = cmd_addr_in;
                        n.awprot    = cmd_prot_in;
                        n.awvalid   = 1'b1;
                        n.wdata     = cmd_wdata_in;
                        n.wstrb     = cmd_wstrb_in;
                        n.wvalid    = 1'b1;
                        n.rsp_rdata = '0;
                        state_d     = WRITE;
                    end else begin
                        n.araddr  = cmd_addr_in;
                        n.arprot  = cmd_prot_in;
                        n.arvalid = 1'b1;
                        state_d   = RADDR;
                    end
                end
            end
            WRITE: begin
                if (axi.awready) n.awvalid = 1'b0;
                if (axi.wready)  n.wvalid  = 1'b0;
                if (!n.awvalid && !n.wvalid) begin
                    n.bready = 1'b1;
                    state_d  = WRESP;
                end
            end
            WRESP: begin
                if (r.bready && axi.bvalid) begin
                    n.bready    = 1'b0;
                    n.rsp_resp  = axi.bresp;
                    n.rsp_valid = 1'b1;
                    state_d     = RSP;
                end
            end
            RADDR: begin
                if (axi.arready) begin
                    n.arvalid = 1'b0;
                    n.rready  = 1'b1;
                    state_d   = RDATA;
                end
            end
            RDATA: begin
                if (r.rready && axi.rvalid) begin
                    n.rready    = 1'b0;
                    n.rsp_rdata = axi.rdata;
                    n.rsp_resp  = axi.rresp;
                    n.rsp_valid = 1'b1;
                    state_d     = RSP;
                end
            end
            RSP: begin
                if (rsp_ready_in) begin
                    n.rsp_valid = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
        if (wd_expire) begin
            n.awvalid   = 1'b0;
            n.wvalid    = 1'b0;
            n.bready    = 1'b0;
            n.arvalid   = 1'b0;
            n.rready    = 1'b0;
            n.rsp_valid = 1'b1;
            n.rsp_resp  = 2'b10;
            n.rsp_rdata = '0;
            state_d     = RSP;
        end
`endif
    end

    assign axi.awaddr    = r.awaddr;
    assign axi.awprot    = r.awprot;
    assign axi.awvalid   = r.awvalid;
    assign axi.wdata     = r.wdata;
    assign axi.wstrb     = r.wstrb;
    assign axi.wvalid    = r.wvalid;
    assign axi.bready    = r.bready;
    assign axi.araddr    = r.araddr;
    assign axi.arprot    = r.arprot;
    assign axi.arvalid   = r.arvalid;
    assign axi.rready    = r.rready;
    assign rsp_valid_out = r.rsp_valid;
    assign rsp_write_out = r.rsp_write;
    assign rsp_resp_out  = r.rsp_resp;
    assign rsp_rdata_out = r.rsp_rdata;
endmodule

// File: tb/tb_axi4_lite_master_adaptor.sv
// tb/tb_axi4_lite_master_adaptor.sv - scoreboard bench for axi4_lite_master_adaptor with a randomized slave model
module tb_axi4_lite_master_adaptor;
    localparam int TO = 8;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic [2:0]  cmd_prot = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_write;
    logic [1:0]  rsp_resp;
    logic [31:0] rsp_rdata;

    axi4_lite_master_adaptor_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

    axi4_lite_master_adaptor #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .aclk(aclk), .areset(areset),
        .cmd_valid_in(cmd_valid), .cmd_ready_out(cmd_ready), .cmd_write_in(cmd_write),
        .cmd_addr_in(cmd_addr), .cmd_prot_in(cmd_prot), .cmd_wdata_in(cmd_wdata), .cmd_wstrb_in(cmd_wstrb),
        .rsp_valid_out(rsp_valid), .rsp_ready_in(rsp_ready), .rsp_write_out(rsp_write),
        .rsp_resp_out(rsp_resp), .rsp_rdata_out(rsp_rdata), .axi(axi)
    );

    always #5 aclk = ~aclk;
    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    typedef struct {
        bit write; logic [31:0] addr; logic [2:0] prot; logic [31:0] wdata; logic [3:0] wstrb;
        logic [1:0] resp; logic [31:0] rdata; int aw_dly, w_dly, ar_dly, b_dly, r_dly; bit hang;
    } cmd_t;
    typedef struct { bit write; logic [1:0] resp; logic [31:0] rdata; } exp_t;

    cmd_t slave_q[$];
    exp_t exp_q[$];
    int checks = 0, errors = 0;
    int rdy_mode = 0;
    bit flush = 0;
    bit aw_seen = 0, w_seen = 0, ar_seen = 0;
    int last_aw_len = 0, last_w_len = 0, rsp_rise_cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Reference: one response per command; writes return no data, a hung slave yields SLVERR.
    function automatic exp_t model(input cmd_t c);
        exp_t e;
        e.write = c.write;
        e.resp  = c.hang ? 2'b10 : c.resp;
        e.rdata = (c.write || c.hang) ? 32'h0 : c.rdata;
        return e;
    endfunction

    function automatic cmd_t base_cmd();
        cmd_t c;
        c.write = 0; c.addr = '0; c.prot = '0; c.wdata = '0; c.wstrb = '0; c.resp = '0; c.rdata = '0;
        c.aw_dly = 0; c.w_dly = 0; c.ar_dly = 0; c.b_dly = 0; c.r_dly = 0; c.hang = 0;
        return c;
    endfunction

    function automatic cmd_t rand_cmd();
        cmd_t c = base_cmd();
        c.write = 1'($urandom); c.addr = $urandom & 32'hFFFC; c.prot = 3'($urandom);
        c.wdata = $urandom; c.wstrb = 4'($urandom); c.resp = 2'($urandom); c.rdata = $urandom;
        c.aw_dly = $urandom_range(0, 3); c.w_dly = $urandom_range(0, 3); c.ar_dly = $urandom_range(0, 3);
        c.b_dly = $urandom_range(0, 3); c.r_dly = $urandom_range(0, 3);
        return c;
    endfunction

    task automatic send(input cmd_t c, output int acc);
        slave_q.push_back(c);
        exp_q.push_back(model(c));
        @(posedge aclk); #1;
        cmd_valid = 1'b1; cmd_write = c.write; cmd_addr = c.addr; cmd_prot = c.prot;
        cmd_wdata = c.wdata; cmd_wstrb = c.wstrb;
        acc = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge aclk);
            if (cmd_ready) begin acc = cyc + 1; break; end
        end
        chk("cmd_accepted", acc >= 0, 1);
        @(posedge aclk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge aclk);
        chk("drain", exp_q.size(), 0);
    endtask

    initial begin : rsp_driver
        forever begin
            @(posedge aclk); #1;
            case (rdy_mode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = ($urandom_range(0, 2) != 0);
                default: rsp_ready = 1'b0;
            endcase
        end
    end

    initial begin : slave
        bit aw_hs, w_hs, b_hs, ar_hs, r_hs, rst_s;
        int aw_wait, w_wait, ar_wait, b_wait, r_wait;
        cmd_t c;
        aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
        axi.awready = 0; axi.wready = 0; axi.arready = 0;
        axi.bvalid = 0; axi.bresp = 0; axi.rvalid = 0; axi.rresp = 0; axi.rdata = 0;
        forever begin
            @(negedge aclk);
            rst_s = areset;
            aw_hs = axi.awvalid && axi.awready;
            w_hs  = axi.wvalid && axi.wready;
            b_hs  = axi.bvalid && axi.bready;
            ar_hs = axi.arvalid && axi.arready;
            r_hs  = axi.rvalid && axi.rready;
            if (!rst_s && slave_q.size() != 0) begin
                c = slave_q[0];
                if (aw_hs) begin chk("awaddr", axi.awaddr, c.addr); chk("awprot", axi.awprot, c.prot); end
                if (w_hs)  begin chk("wdata", axi.wdata, c.wdata); chk("wstrb", axi.wstrb, c.wstrb); end
                if (ar_hs) begin chk("araddr", axi.araddr, c.addr); chk("arprot", axi.arprot, c.prot); end
            end
            @(posedge aclk); #1;
            if (rst_s || flush || b_hs || r_hs) begin
                if (rst_s) slave_q.delete();
                else if (slave_q.size() != 0) void'(slave_q.pop_front());
                flush = 0; aw_seen = 0; w_seen = 0; ar_seen = 0;
                aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
                axi.bvalid = 0; axi.rvalid = 0;
            end else begin
                if (aw_hs) aw_seen = 1;
                if (w_hs)  w_seen = 1;
                if (ar_hs) ar_seen = 1;
            end
            axi.awready = 0; axi.wready = 0; axi.arready = 0;
            if (!rst_s && slave_q.size() != 0) begin
                c = slave_q[0];
                if (axi.awvalid && !aw_seen) begin if (aw_wait >= c.aw_dly) axi.awready = 1; else aw_wait++; end
                if (axi.wvalid && !w_seen)   begin if (w_wait >= c.w_dly) axi.wready = 1; else w_wait++; end
                if (axi.arvalid && !ar_seen) begin if (ar_wait >= c.ar_dly) axi.arready = 1; else ar_wait++; end
                if (aw_seen && w_seen && !axi.bvalid && !c.hang) begin
                    if (b_wait >= c.b_dly) begin axi.bvalid = 1; axi.bresp = c.resp; end else b_wait++;
                end
                if (ar_seen && !axi.rvalid && !c.hang) begin
                    if (r_wait >= c.r_dly) begin axi.rvalid = 1; axi.rdata = c.rdata; axi.rresp = c.resp; end
                    else r_wait++;
                end
            end
        end
    end

    initial begin : monitor
        bit pend_rsp, pend_aw, pend_w, pend_ar, prev_rv;
        logic [34:0] prev_rsp, prev_aw, prev_ar;
        logic [35:0] prev_w;
        int aw_len, w_len;
        exp_t e;
        pend_rsp = 0; pend_aw = 0; pend_w = 0; pend_ar = 0; prev_rv = 0; aw_len = 0; w_len = 0;
        forever begin
            @(negedge aclk);
            if (areset) begin
                pend_rsp = 0; pend_aw = 0; pend_w = 0; pend_ar = 0; prev_rv = 0; aw_len = 0; w_len = 0;
                continue;
            end
            if (pend_rsp) chk("rsp_hold", {rsp_valid, rsp_write, rsp_resp, rsp_rdata}, {1'b1, prev_rsp});
            if (pend_aw)  chk("aw_hold", {axi.awvalid, axi.awaddr, axi.awprot}, {1'b1, prev_aw});
            if (pend_w)   chk("w_hold", {axi.wvalid, axi.wdata, axi.wstrb}, {1'b1, prev_w});
            if (pend_ar)  chk("ar_hold", {axi.arvalid, axi.araddr, axi.arprot}, {1'b1, prev_ar});
            if (axi.bready) chk("bready_after_aw_w", aw_seen && w_seen, 1);
            if (rsp_valid) chk("cmd_ready_in_rsp", cmd_ready, 0);
            if (rsp_valid && !prev_rv) rsp_rise_cyc = cyc;
            if (rsp_valid && rsp_ready) begin
                chk("rsp_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("rsp_write", rsp_write, e.write);
                    chk("rsp_resp", rsp_resp, e.resp);
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                end
            end
            if (axi.awvalid) aw_len++;
            if (axi.awvalid && axi.awready) begin last_aw_len = aw_len; aw_len = 0; end
            if (axi.wvalid) w_len++;
            if (axi.wvalid && axi.wready) begin last_w_len = w_len; w_len = 0; end
            pend_rsp = rsp_valid && !rsp_ready;      prev_rsp = {rsp_write, rsp_resp, rsp_rdata};
            pend_aw  = axi.awvalid && !axi.awready;  prev_aw  = {axi.awaddr, axi.awprot};
            pend_w   = axi.wvalid && !axi.wready;    prev_w   = {axi.wdata, axi.wstrb};
            pend_ar  = axi.arvalid && !axi.arready;  prev_ar  = {axi.araddr, axi.arprot};
            prev_rv  = rsp_valid;
        end
    end

    task automatic check_all_zero(input string name);
        chk({name, "_valids"}, {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready, rsp_valid}, 0);
        chk({name, "_payload"}, |{axi.awaddr, axi.awprot, axi.wdata, axi.wstrb, axi.araddr, axi.arprot,
                                  rsp_write, rsp_resp, rsp_rdata}, 0);
        chk({name, "_cmd_ready"}, cmd_ready, 0);
    endtask

    initial begin : stimulus
        int acc;
        cmd_t c;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check_all_zero("reset");
        @(posedge aclk); #1 areset = 1'b0;
        @(negedge aclk);
        chk("cmd_ready_idle", cmd_ready, 1);

        c = base_cmd(); c.write = 1; c.addr = 32'h10; c.wdata = 32'hDEADBEEF; c.wstrb = 4'hF;
        send(c, acc);
        drain();
        chk("write_latency", rsp_rise_cyc - acc, 2);
        @(negedge aclk);
        chk("cmd_ready_after_rsp", cmd_ready, 1);

        c = base_cmd(); c.write = 1; c.addr = 32'h44; c.wdata = 32'h01234567; c.wstrb = 4'h5;
        c.aw_dly = 3; c.resp = 2'b01;
        send(c, acc);
        drain();
        chk("skew_awvalid_len", last_aw_len, 4);
        chk("skew_wvalid_len", last_w_len, 1);

        c = base_cmd(); c.addr = 32'h20; c.ar_dly = 2; c.rdata = 32'hCAFEF00D;
        send(c, acc);
        drain();

        rdy_mode = 2;
        c = rand_cmd(); c.write = 0;
        send(c, acc);
        for (int i = 0; i < 100 && !rsp_valid; i++) @(negedge aclk);
        chk("bp_rsp_seen", rsp_valid, 1);
        repeat (5) begin
            @(negedge aclk);
            chk("bp_cmd_ready", cmd_ready, 0);
        end
        rdy_mode = 0;
        drain();

        rdy_mode = 1;
        repeat (40) begin
            c = rand_cmd();
            send(c, acc);
        end
        drain();
        rdy_mode = 0;

        c = base_cmd(); c.write = 1; c.addr = 32'h80; c.wdata = 32'h55AA55AA; c.wstrb = 4'hF; c.b_dly = 20;
        send(c, acc);
        for (int i = 0; i < 100 && !axi.bready; i++) @(negedge aclk);
        chk("mid_reset_in_wresp", axi.bready, 1);
        @(posedge aclk); #1;
        areset = 1'b1;
        exp_q.delete();
        @(negedge aclk);
        chk("mid_reset_cmd_ready", cmd_ready, 0);
        @(negedge aclk);
        check_all_zero("mid_reset");
        @(posedge aclk); #1 areset = 1'b0;
        @(negedge aclk);
        chk("post_reset_cmd_ready", cmd_ready, 1);
        c = rand_cmd(); c.write = 1;
        send(c, acc);
        drain();

`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
        c = base_cmd(); c.write = 1; c.addr = 32'hC0; c.wdata = 32'h0BADF00D; c.wstrb = 4'hF; c.hang = 1;
        send(c, acc);
        drain();
        chk("timeout_latency", rsp_rise_cyc - acc, TO);
        flush = 1;
        repeat (3) @(posedge aclk);
        c = rand_cmd(); c.write = 0;
        send(c, acc);
        drain();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
